rca_seq_ctrl: RTL and testbench

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_pkg.sv | 15 +
 rtl/rca_8bit.sv | 29 ++
 rtl/rca_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the sequential ripple-carry adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rca_pkg;

    // Datapath slice width; the sequencer walks the operand in slices of this size.
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_state_t;

endpackage

// File: rtl/rca_8bit.sv
// Combinational 8-bit ripple-carry adder slice: s/co = a + b + ci.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b - addend slices; ci - carry in; s - sum slice; co - carry out.
module rca_8bit
    import rca_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] s,
    output logic              co
);

    logic c;

    // Explicit bit-serial carry chain rather than a '+' so the slice stays a
    // true ripple-carry structure.
    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < BYTE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential adder: sum/cout = a + b + cin, one byte per cycle LSB first through one rca_8bit.
// Latency: done pulses NBYTES cycles after the accepting start edge; back-to-back start allowed in DONE.
// Backpressure: none; start is ignored while busy (RUN), caller must wait for done.
// Ports: clk, rst_n (async active-low); start, a, b, cin request an operation;
//        busy (RUN), done (1-cycle pulse), sum, cout hold the result until the next accepted start.
// Optional: define RCA_SEQ_SUB_EN to add input 'sub' (sub=1 computes a - b, cout=1 means no borrow).
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                     sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int W    = BYTE_W * NBYTES;

    rca_state_t       state, state_nxt;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [W-1:0]     a_q, b_q;
    logic [BYTE_W-1:0] a_byte, b_byte, add_s;
    logic             add_co;
    logic             last_byte;
    logic             accept;
    logic [W-1:0]     b_in;
    logic             c_in;

    // Operand conditioning at accept: subtraction is a + ~b + 1.
`ifdef RCA_SEQ_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // start is only honoured outside RUN, which also gives back-to-back from DONE.
    assign accept    = start && (state != RUN);
    assign last_byte = (int'(idx) == NBYTES - 1);

    // Byte mux feeding the single adder slice.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (int'(idx) == i) begin
                a_byte = a_q[i*BYTE_W +: BYTE_W];
                b_byte = b_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    rca_8bit u_add (
        .a  (a_byte),
        .b  (b_byte),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_byte) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b_in;
            carry <= c_in;
            idx   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (int'(idx) == i) sum[i*BYTE_W +: BYTE_W] <= add_s;
            end
            carry <= add_co;
            idx   <= idx + 1'b1;
            if (last_byte) cout <= add_co;
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (NBYTES=4): vector table plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_rca_seq_ctrl;
    import rca_pkg::*;

    localparam int LIMIT = 20;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        cin;
    logic        sub;
    logic        busy, done, cout;
    logic [31:0] sum;

    int checks   = 0;
    int failures = 0;

    rca_seq_ctrl #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drive a request; caller is positioned at a falling edge.
    task automatic op_start(input logic [31:0] av, input logic [31:0] bv,
                            input logic ci, input logic sb);
        a     = av;
        b     = bv;
        cin   = ci;
        sub   = sb;
        start = 1'b1;
    endtask

    // Drops start after the accepting edge, then waits (bounded) for done.
    // lat counts clock edges from the accepting edge to the edge that raised done.
    task automatic wait_done(output int lat, output int bcnt, output logic overlap);
        lat     = -1;
        bcnt    = 0;
        overlap = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = k - 1;
                break;
            end
            if (busy) bcnt++;
        end
        if (lat < 0) begin
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", LIMIT);
        end
    endtask

    task automatic check_result(input string nm, input logic [31:0] es, input logic eco,
                                input int lat, input int bcnt, input logic overlap);
        check({nm, "_sum"},     sum,     es);
        check({nm, "_cout"},    32'(cout), 32'(eco));
        check({nm, "_latency"}, lat,     4);
        check({nm, "_busycyc"}, bcnt,    4);
        check({nm, "_overlap"}, 32'(overlap), 0);
    endtask

    // One cycle after done with start low: pulse over, back in IDLE, result held.
    task automatic check_after(input string nm, input logic [31:0] es, input logic eco);
        @(negedge clk);
        check({nm, "_done_1cyc"}, 32'(done), 0);
        check({nm, "_idle"},      32'(dut.state == IDLE), 1);
        check({nm, "_sum_hold"},  sum, es);
        check({nm, "_cout_hold"}, 32'(cout), 32'(eco));
    endtask

    vec_t vecs[8];
    int   lat, bcnt;
    logic ovl;
    logic done_seen;

    initial begin
        vecs[0] = '{32'h000000B5, 32'h000000F3, 1'b0, 1'b0, 32'h000001A8, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;

        #12;
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_sum",   sum, 0);
        check("rst_cout",  32'(cout), 0);
        check("rst_state", 32'(dut.state == IDLE), 1);

        // Release reset and request on the same falling edge: first edge must accept.
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            op_start(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_done(lat, bcnt, ovl);
            check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, lat, bcnt, ovl);
            check_after($sformatf("vec%0d", i), vecs[i].s, vecs[i].co);
        end

        // Back-to-back: new start presented in the DONE cycle.
        op_start(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0);
        wait_done(lat, bcnt, ovl);
        check_result("b2b_first", 32'h00000000, 1'b1, lat, bcnt, ovl);
        op_start(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        wait_done(lat, bcnt, ovl);
        check_result("b2b_second", 32'h00000003, 1'b0, lat, bcnt, ovl);
        check_after("b2b_second", 32'h00000003, 1'b0);

        // start re-asserted with new operands during RUN must be ignored.
        op_start(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        lat = -1;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a   = 32'hFFFFFFFF;
                b   = 32'hFFFFFFFF;
                cin = 1'b1;
            end
            if (k == 4) start = 1'b0;
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        check("ign_latency", lat, 4);
        check("ign_sum",     sum, 32'h33333333);
        check("ign_cout",    32'(cout), 0);
        check_after("ign", 32'h33333333, 1'b0);

        // Reset after two RUN edges: everything clears, no done pulse.
        op_start(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_done",  32'(done), 0);
        check("mid_rst_sum",   sum, 0);
        check("mid_rst_cout",  32'(cout), 0);
        check("mid_rst_state", 32'(dut.state == IDLE), 1);
        check("mid_rst_idx",   32'(dut.idx), 0);
        check("mid_rst_carry", 32'(dut.carry), 0);
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("mid_rst_nodone", 32'(done_seen), 0);
        rst_n = 1'b1;
        op_start(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0);
        wait_done(lat, bcnt, ovl);
        check_result("post_rst", 32'hDFAEBFF0, 1'b0, lat, bcnt, ovl);
        check_after("post_rst", 32'hDFAEBFF0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
        // cin is deliberately 1 to show it is ignored under sub.
        op_start(32'd5, 32'd7, 1'b1, 1'b1);
        wait_done(lat, bcnt, ovl);
        check_result("sub_5m7", 32'hFFFFFFFE, 1'b0, lat, bcnt, ovl);
        op_start(32'd7, 32'd5, 1'b0, 1'b1);
        wait_done(lat, bcnt, ovl);
        check_result("sub_7m5", 32'h00000002, 1'b1, lat, bcnt, ovl);
        check_after("sub_7m5", 32'h00000002, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
